// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array load and drain controllers.
package systolic_pkg;

   localparam int INPUT_W_DEF    = 8;
   localparam int DATA_W_DEF     = 32;
   localparam int ARRAY_SIZE_DEF = 4;
   localparam int ADDR_W         = 10;

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      STORE,
      DONE
   } state_t;

   // Load/skew controller states live here too, so their names carry a prefix.
   typedef enum logic [1:0] {
      LD_IDLE,
      LD_FETCH,
      LD_SKEW,
      LD_DONE
   } load_state_t;

endpackage

// File: rtl/output_drain_unit_if.sv
// Memory write port of the output drain unit.
interface output_drain_unit_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_en;
   logic              mem_wr_ack;

   modport master (
      output mem_addr,
      output mem_wr_data,
      output mem_wr_en,
      input  mem_wr_ack
   );

   modport slave (
      input  mem_addr,
      input  mem_wr_data,
      input  mem_wr_en,
      output mem_wr_ack
   );
endinterface

// File: rtl/output_deskew.sv
// Output buffer: captures the skewed bottom-row results into OBUF[row][col].
module output_deskew
   import systolic_pkg::*;
#(
   parameter  int ARRAY_SIZE = ARRAY_SIZE_DEF,
   parameter  int DATA_W     = DATA_W_DEF,
   localparam int CW         = $clog2(2 * ARRAY_SIZE),
   localparam int SW         = $clog2(ARRAY_SIZE * ARRAY_SIZE)
) (
   input  logic                                clk,
   input  logic                                nRST,
   input  logic                                cap_clr,
   input  logic                                cap_en,
   output logic                                cap_last,
   input  logic [ARRAY_SIZE-1:0][DATA_W-1:0]   psum_in,
   input  logic [SW-1:0]                       rd_index,
   output logic [DATA_W-1:0]                   rd_data
);
   localparam int RW = $clog2(ARRAY_SIZE);

   logic [CW-1:0]     cap_count;
   logic [DATA_W-1:0] obuf [ARRAY_SIZE][ARRAY_SIZE];
   logic [RW-1:0]     rd_row;
   logic [RW-1:0]     rd_col;

   assign cap_last = (cap_count == CW'(2 * ARRAY_SIZE - 2));

   always_ff @(posedge clk) begin
      if (!nRST) begin
         cap_count <= '0;
      end else if (cap_clr) begin
         cap_count <= '0;
      end else if (cap_en && !cap_last) begin
         cap_count <= cap_count + 1'b1;
      end
   end

   // Column c carries row (cap_count - c) this cycle; lanes outside the diagonal are ignored.
   always_ff @(posedge clk) begin
      if (!nRST) begin
         for (int r = 0; r < ARRAY_SIZE; r++)
            for (int c = 0; c < ARRAY_SIZE; c++)
               obuf[r][c] <= '0;
      end else begin
         for (int r = 0; r < ARRAY_SIZE; r++)
            for (int c = 0; c < ARRAY_SIZE; c++)
               if (cap_en && int'(cap_count) == r + c)
                  obuf[r][c] <= psum_in[c];
      end
   end

   assign rd_row  = RW'(rd_index / SW'(ARRAY_SIZE));
   assign rd_col  = RW'(rd_index % SW'(ARRAY_SIZE));
   assign rd_data = obuf[rd_row][rd_col];

endmodule

// File: rtl/output_drain_unit.sv
// Drains the systolic array results into memory, one word per acknowledged write.
// Define OUTPUT_RELU_EN to clamp negative results to zero on the write path.
module output_drain_unit
   import systolic_pkg::*;
#(
   parameter int INPUT_W    = INPUT_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int ARRAY_SIZE = ARRAY_SIZE_DEF
) (
   input  logic                              clk,
   input  logic                              nRST,
   input  logic                              start,
   input  logic [ADDR_W-1:0]                 output_base_addr,
   input  logic [ARRAY_SIZE-1:0][DATA_W-1:0] psum_in,
   output_drain_unit_if.master               mem,
   output logic                              busy,
   output logic                              done
);
   // state   | meaning
   // IDLE    | waiting for start
   // CAPTURE | de-skewing 2*ARRAY_SIZE-1 cycles of psum_in into OBUF
   // STORE   | writing OBUF row-major, advancing on mem_wr_ack
   // DONE    | one-cycle done pulse

   localparam int SW = $clog2(ARRAY_SIZE * ARRAY_SIZE);
   localparam logic [SW-1:0] ST_LAST = SW'(ARRAY_SIZE * ARRAY_SIZE - 1);

   // A result must be able to hold the product of two operands.
   if (DATA_W < 2 * INPUT_W) begin : g_width_check
      $error("DATA_W too narrow for INPUT_W operands");
   end

   state_t            state, state_nxt;
   logic [SW-1:0]     st_count;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] rd_data;
   logic [DATA_W-1:0] wr_data;
   logic              cap_clr, cap_en, cap_last, wr_en;

   output_deskew #(
      .ARRAY_SIZE (ARRAY_SIZE),
      .DATA_W     (DATA_W)
   ) u_deskew (
      .clk      (clk),
      .nRST     (nRST),
      .cap_clr  (cap_clr),
      .cap_en   (cap_en),
      .cap_last (cap_last),
      .psum_in  (psum_in),
      .rd_index (st_count),
      .rd_data  (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!nRST) begin
         state     <= IDLE;
         st_count  <= '0;
         base_addr <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            base_addr <= output_base_addr;
            st_count  <= '0;
         end else if (state == STORE && mem.mem_wr_ack) begin
            st_count <= st_count + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cap_clr   = 1'b0;
      cap_en    = 1'b0;
      wr_en     = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               cap_clr   = 1'b1;
               state_nxt = CAPTURE;
            end
         end
         CAPTURE: begin
            cap_en = 1'b1;
            if (cap_last) state_nxt = STORE;
         end
         STORE: begin
            wr_en = 1'b1;
            if (mem.mem_wr_ack && st_count == ST_LAST) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef OUTPUT_RELU_EN
   assign wr_data = rd_data[DATA_W-1] ? '0 : rd_data;
`else
   assign wr_data = rd_data;
`endif

   assign wr_addr         = base_addr + ADDR_W'(st_count);
   assign mem.mem_wr_en   = wr_en;
   assign mem.mem_addr    = wr_en ? 32'(wr_addr) : '0;
   assign mem.mem_wr_data = wr_en ? wr_data : '0;

endmodule

// File: tb/tb_output_drain_unit.sv
// Scoreboard bench for output_drain_unit: expected writes queued at stimulus, checked by a monitor.
module tb_output_drain_unit;
   localparam int N  = 4;
   localparam int DW = 32;
`ifdef OUTPUT_RELU_EN
   localparam logic [31:0] NEG_EXP = 32'h0;
`else
   localparam logic [31:0] NEG_EXP = 32'hFFFF_FFF6;
`endif

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic                   clk = 1'b0;
   logic                   nRST = 1'b0;
   logic                   start = 1'b0;
   logic [9:0]             base_addr = '0;
   logic [N-1:0][DW-1:0]   psum = '0;
   logic                   busy, done;

   output_drain_unit_if #(.DATA_W(DW)) mem_if ();

   output_drain_unit #(.INPUT_W(8), .DATA_W(DW), .ARRAY_SIZE(N)) dut (
      .clk              (clk),
      .nRST             (nRST),
      .start            (start),
      .output_base_addr (base_addr),
      .psum_in          (psum),
      .mem              (mem_if),
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  acc_count = 0;
   int  done_count = 0;
   int  done_cyc = 0;
   bit  stall_en = 0;
   int  stall_left = 0;
   bit  start_in_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Ack is decided just after each edge from the count of writes accepted so far.
   initial mem_if.mem_wr_ack = 1'b1;
   always @(posedge clk) begin
      #1;
      if (stall_en && acc_count == 5 && stall_left > 0) begin
         mem_if.mem_wr_ack = 1'b0;
         stall_left--;
      end else begin
         mem_if.mem_wr_ack = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (nRST) begin
         if (mem_if.mem_wr_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write",
                        mem_if.mem_addr, mem_if.mem_wr_data);
            end else begin
               check($sformatf("wr_addr[%0d]", acc_count), mem_if.mem_addr, exp_q[0].addr);
               check($sformatf("wr_data[%0d]", acc_count), mem_if.mem_wr_data, exp_q[0].data);
               if (mem_if.mem_wr_ack) begin
                  void'(exp_q.pop_front());
                  acc_count++;
               end
            end
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
            if (start_in_done) start = 1'b1;
         end
      end
   end

   task automatic run_drain(input string tag, input logic [9:0] b, input bit inj, input bit neg,
                            input int rst_at, input int exp_lat);
      int  s_cyc, dc0, t, r;
      wr_t e;
      acc_count = 0;
      dc0 = done_count;
      for (int i = 0; i < N * N; i++) begin
         e.addr = 32'((int'(b) + i) % 1024);
         e.data = 32'(100 * (i / N) + i % N);
         if (neg && i == 6) e.data = NEG_EXP;
         exp_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b1;
      base_addr = b;
      s_cyc = cyc;
      for (int k = 0; k < 2 * N - 1; k++) begin
         @(negedge clk);
         start = inj && (k == 3);
         for (int c = 0; c < N; c++) begin
            r = k - c;
            if (r >= 0 && r < N) psum[c] = 32'(100 * r + c);
            else psum[c] = 32'hDEAD_0000 | 32'(c);
            if (neg && r == 1 && c == 2) psum[c] = 32'hFFFF_FFF6;
         end
      end
      @(negedge clk);
      psum = {N{32'hBAD0_BAD0}};
      start = inj;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      while (done_count == dc0 && t < 300) begin
         @(posedge clk);
         #1;
         t++;
         if (rst_at >= 0 && acc_count == rst_at) begin
            nRST = 1'b0;
            @(posedge clk);
            #1;
            check({tag, "_rst_wr_en"}, 32'(mem_if.mem_wr_en), 32'd0);
            check({tag, "_rst_busy"}, 32'(busy), 32'd0);
            check({tag, "_rst_addr"}, mem_if.mem_addr, 32'd0);
            for (int rr = 0; rr < N; rr++)
               for (int cc = 0; cc < N; cc++)
                  check($sformatf("%s_obuf[%0d][%0d]", tag, rr, cc), dut.u_deskew.obuf[rr][cc], 32'd0);
            nRST = 1'b1;
            exp_q.delete();
            return;
         end
      end
      if (t >= 300) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done within 300 cycles, required done", tag);
         exp_q.delete();
         return;
      end
      check({tag, "_latency"}, 32'(done_cyc - s_cyc), 32'(exp_lat));
      if (start_in_done) begin
         check({tag, "_start_in_done_ignored"}, 32'(busy), 32'd0);
         @(posedge clk);
         #1;
         check({tag, "_start_after_done_taken"}, 32'(busy), 32'd1);
         start = 1'b0;
         start_in_done = 0;
         nRST = 1'b0;
         @(posedge clk);
         #1;
         nRST = 1'b1;
         return;
      end
      repeat (3) @(posedge clk);
      #1;
      check({tag, "_done_pulses"}, 32'(done_count - dc0), 32'd1);
      check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      nRST = 1'b1;
      @(negedge clk);
      check("reset_wr_en", 32'(mem_if.mem_wr_en), 32'd0);
      check("reset_addr", mem_if.mem_addr, 32'd0);
      check("reset_data", mem_if.mem_wr_data, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);

      run_drain("identity", 10'h040, 0, 0, -1, 24);

      stall_en = 1;
      stall_left = 3;
      run_drain("stall", 10'h040, 0, 0, -1, 27);
      stall_en = 0;

      run_drain("wrap", 10'h3FC, 0, 0, -1, 24);
      run_drain("ignored_start", 10'h080, 1, 0, -1, 24);

      start_in_done = 1;
      run_drain("done_start", 10'h0C0, 0, 0, -1, 24);

      run_drain("mid_reset", 10'h200, 0, 0, 7, 24);
      run_drain("after_reset", 10'h000, 0, 0, -1, 24);
      run_drain("signed", 10'h100, 0, 1, -1, 24);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
